// File: rtl/postprocess_result_buffer.sv
// Result FIFO behind PostProcess: buffers float pairs and serialises them as
// tagged 32-bit words with class decision and frame framing.
module postprocess_result_buffer #(
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int ITER_W    = 9
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic [ITER_W-1:0]          in_iter,
    input  logic [31:0]                in_float0,
    input  logic [31:0]                in_float1,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic                       out_sel,
    output logic [ITER_W-1:0]          out_iter,
    output logic                       out_class,
    output logic                       out_last,
    output logic                       frame_done,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef struct packed {
        logic [ITER_W-1:0] iter;
        logic [31:0]       f0;
        logic [31:0]       f1;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WORD0 = 2'd1,
        WORD1 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    entry_t          head;
    logic            pop;
    logic            push;
    logic            full;
    logic            at_last;
    logic            is_nan;

    always_comb begin
        head    = mem_q[rptr_q];
        at_last = (fcnt_q == FW'(FRAME_LEN - 1));
        full    = (level_q == LW'(DEPTH));
        pop     = (state_q == WORD1) && out_ready;
        // A full FIFO still takes a pair when the head leaves this cycle
        push    = in_valid && (!full || pop);
    end

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        fcnt_d  = fcnt_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        if (clear) begin
            state_d = EMPTY;
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            fcnt_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = '{iter: in_iter, f0: in_float0, f1: in_float1};
                wptr_d        = wptr_q + PW'(1);
            end else if (in_valid) begin
                ovf_d = 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
                fcnt_d = at_last ? '0 : fcnt_q + FW'(1);
                done_d = at_last;
            end
            level_d = level_q + LW'(push) - LW'(pop);
            unique case (state_q)
                EMPTY: if (level_q != '0) state_d = WORD0;
                WORD0: if (out_ready) state_d = WORD1;
                WORD1: if (out_ready) state_d = (level_d != '0) ? WORD0 : EMPTY;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= EMPTY;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            fcnt_q  <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            fcnt_q  <= fcnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        out_valid = (state_q != EMPTY);
        out_sel   = (state_q == WORD1);
        out_last  = (state_q == WORD1) && at_last;
        out_iter  = out_valid ? head.iter : '0;
        unique case (state_q)
            WORD0:   out_data = head.f0;
            WORD1:   out_data = head.f1;
            default: out_data = '0;
        endcase
        // Magnitude compare works on the raw bits; NaN must be excluded
        is_nan    = (&out_data[30:23]) && (|out_data[22:0]);
        out_class = !out_data[31] && (out_data[30:0] > 31'h3F000000) && !is_nan;
    end

    assign frame_done = done_q;
    assign overflow   = ovf_q;
    assign level      = level_q;

endmodule

// File: tb/tb_postprocess_result_buffer.sv
// Directed bench for postprocess_result_buffer: latency, backpressure,
// overflow, framing, class boundaries and async reset.
module tb_postprocess_result_buffer;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        clear;
    logic        in_valid;
    logic [8:0]  in_iter;
    logic [31:0] in_float0;
    logic [31:0] in_float1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sel;
    logic [8:0]  out_iter;
    logic        out_class;
    logic        out_last;
    logic        frame_done;
    logic        overflow;
    logic [3:0]  level;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    postprocess_result_buffer #(.DEPTH(8), .FRAME_LEN(4), .ITER_W(9)) dut (
        .clk(clk), .rst_b(rst_b), .clear(clear),
        .in_valid(in_valid), .in_iter(in_iter),
        .in_float0(in_float0), .in_float1(in_float1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel(out_sel), .out_iter(out_iter),
        .out_class(out_class), .out_last(out_last),
        .frame_done(frame_done), .overflow(overflow), .level(level)
    );

    function automatic logic [31:0] pf0(input int i);
        return 32'h41000000 + 32'(i);
    endfunction

    function automatic logic [31:0] pf1(input int i);
        return 32'hC1000000 + 32'(i);
    endfunction

    task automatic drive_pair(input int i);
        in_valid  = 1'b1;
        in_iter   = 9'(i + 16);
        in_float0 = pf0(i);
        in_float1 = pf1(i);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        clear    = 1'b0;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_iter = '0; in_float0 = '0; in_float1 = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({out_valid, out_sel, out_last, frame_done, overflow} !== 5'b0 ||
            out_data !== 32'h0 || out_iter !== 9'h0 || level !== 4'd0) begin
            miscompares++;
            $display("FAIL reset: valid=%b sel=%b last=%b done=%b ovf=%b data=%h iter=%h level=%0d, required all 0",
                     out_valid, out_sel, out_last, frame_done, overflow, out_data, out_iter, level);
        end
        rst_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid = 1'b1; in_iter = 9'h005;
        in_float0 = 32'h3F400000; in_float1 = 32'h3E800000;
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || level !== 4'd1) begin
            miscompares++;
            $display("FAIL single_latency: valid=%b level=%0d, required 0 and 1", out_valid, level);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h3F400000 || out_sel !== 1'b0 ||
            out_class !== 1'b1 || out_iter !== 9'h005) begin
            miscompares++;
            $display("FAIL single_word0: valid=%b data=%h sel=%b class=%b iter=%h, required 1 3f400000 0 1 005",
                     out_valid, out_data, out_sel, out_class, out_iter);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h3E800000 || out_sel !== 1'b1 ||
            out_class !== 1'b0 || out_iter !== 9'h005 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL single_word1: valid=%b data=%h sel=%b class=%b iter=%h last=%b, required 1 3e800000 1 0 005 0",
                     out_valid, out_data, out_sel, out_class, out_iter, out_last);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || level !== 4'd0) begin
            miscompares++;
            $display("FAIL single_drain: valid=%b level=%0d, required 0 0", out_valid, level);
        end
    endtask

    task automatic test_backpressure();
        do_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_pair(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== pf0(0) || out_sel !== 1'b0 || level !== 4'd3) begin
                miscompares++;
                $display("FAIL bp_hold c%0d: valid=%b data=%h sel=%b level=%0d, required 1 %h 0 3",
                         c, out_valid, out_data, out_sel, level, pf0(0));
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== ((k % 2 == 0) ? pf0(k / 2) : pf1(k / 2)) ||
                out_sel !== 1'(k % 2) || out_iter !== 9'(k / 2 + 16)) begin
                miscompares++;
                $display("FAIL bp_release w%0d: valid=%b data=%h sel=%b iter=%h", k, out_valid, out_data, out_sel, out_iter);
            end
            @(negedge clk);
        end
        vectors++;
        if (out_valid !== 1'b0 || level !== 4'd0) begin
            miscompares++;
            $display("FAIL bp_empty: valid=%b level=%0d, required 0 0", out_valid, level);
        end
    endtask

    task automatic test_overflow();
        int exp_idx;
        do_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin
                vectors++;
                if (level !== 4'd8 || overflow !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ovf_full: level=%0d ovf=%b, required 8 0", level, overflow);
                end
            end
            drive_pair(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        vectors++;
        if (level !== 4'd8 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_drop: level=%0d ovf=%b, required 8 1", level, overflow);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_iter = 9'h055;
        in_float0 = 32'h11111111; in_float1 = 32'h22222222;
        vectors++;
        if (out_sel !== 1'b1 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_word1: valid=%b sel=%b, required 1 1", out_valid, out_sel);
        end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (level !== 4'd8 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_pushpop: level=%0d ovf=%b, required 8 1", level, overflow);
        end
        for (int k = 0; k < 16; k++) begin
            logic [31:0] exp;
            exp_idx = k / 2 + 1;
            if (exp_idx == 8) exp = (k % 2 == 0) ? 32'h11111111 : 32'h22222222;
            else              exp = (k % 2 == 0) ? pf0(exp_idx) : pf1(exp_idx);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                miscompares++;
                $display("FAIL ovf_drain w%0d: valid=%b data=%h, required 1 %h", k, out_valid, out_data, exp);
            end
            @(negedge clk);
        end
        vectors++;
        if (out_valid !== 1'b0 || level !== 4'd0) begin
            miscompares++;
            $display("FAIL ovf_empty: valid=%b level=%0d, required 0 0", out_valid, level);
        end
    endtask

    task automatic test_framing();
        int n = 0;
        logic prev_last = 1'b0;
        do_clear();
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c < 8) drive_pair(c);
            else in_valid = 1'b0;
            vectors++;
            if (frame_done !== prev_last) begin
                miscompares++;
                $display("FAIL frame_done c%0d: got %b, required %b", c, frame_done, prev_last);
            end
            if (out_valid === 1'b1) begin
                n++;
                vectors++;
                if (out_last !== (n == 8 || n == 16) ||
                    out_data !== (((n - 1) % 2 == 0) ? pf0((n - 1) / 2) : pf1((n - 1) / 2))) begin
                    miscompares++;
                    $display("FAIL frame_word %0d: last=%b data=%h", n, out_last, out_data);
                end
                prev_last = out_last;
            end else begin
                prev_last = 1'b0;
            end
            @(negedge clk);
        end
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL frame_count: got %0d words, required 16", n);
        end
    endtask

    task automatic test_class();
        logic [31:0] a [3] = '{32'h3F000000, 32'hBF400000, 32'h7FC00000};
        logic [31:0] b [3] = '{32'h3F000001, 32'h7F800000, 32'h00000000};
        logic        ea [3] = '{1'b0, 1'b0, 1'b0};
        logic        eb [3] = '{1'b1, 1'b1, 1'b0};
        do_clear();
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1; in_iter = 9'(j);
            in_float0 = a[j]; in_float1 = b[j];
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            vectors++;
            if (out_data !== a[j] || out_class !== ea[j]) begin
                miscompares++;
                $display("FAIL class %h: data=%h class=%b, required %b", a[j], out_data, out_class, ea[j]);
            end
            out_ready = 1'b1;
            @(negedge clk);
            vectors++;
            if (out_data !== b[j] || out_class !== eb[j]) begin
                miscompares++;
                $display("FAIL class %h: data=%h class=%b, required %b", b[j], out_data, out_class, eb[j]);
            end
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        int stale = 0;
        do_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_pair(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (out_sel !== 1'b1 || level !== 4'd4) begin
            miscompares++;
            $display("FAIL arst_setup: sel=%b level=%0d, required 1 4", out_sel, level);
        end
        #2 rst_b = 1'b0;
        #1;
        vectors++;
        if ({out_valid, out_sel, out_last, frame_done, overflow} !== 5'b0 ||
            out_data !== 32'h0 || out_iter !== 9'h0 || level !== 4'd0) begin
            miscompares++;
            $display("FAIL arst_immediate: valid=%b sel=%b data=%h iter=%h level=%0d, required all 0",
                     out_valid, out_sel, out_data, out_iter, level);
        end
        @(negedge clk);
        rst_b = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        vectors++;
        if (stale != 0 || level !== 4'd0) begin
            miscompares++;
            $display("FAIL arst_stale: %0d valid cycles, level=%0d, required 0 0", stale, level);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_framing();
        test_class();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
